// File: rtl/riscos_loader.sv
// riscos_loader: zero-fills SDRAM on a RISC OS download, then packs 16-bit ioctl halfwords into 32-bit wishbone writes at ROM_BASE.
// Latency: a bus request rises one cycle after the decision; ioctl_wait clears the cycle after the final ack of a sequence.
// Backpressure: ioctl_wait stalls the HPS while any write is outstanding; halfwords arriving under ioctl_wait are dropped and flag overrun.
module riscos_loader #(
  parameter int          ERASE_WORDS = 1 << 20,
  parameter logic [23:0] ROM_BASE    = 24'h100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [23:0] wb_adr,
  output logic [31:0] wb_dat,
  input  logic        wb_ack,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, ERASE, LOAD, WRITE, FLUSH, FINISH} state_t;

  // One wishbone write: word address, byte enables, data.
  typedef struct packed {
    logic [23:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  localparam logic [23:0] ERASE_LAST = 24'(ERASE_WORDS - 1);

  state_t      state, state_nxt;
  logic        dl_prev;
  logic        stb;
  req_t        bus;
  logic        pend_vld;
  req_t        pend;
  logic        lat_vld;
  logic [23:0] lat_word;
  logic [15:0] lat_half;
  logic [23:0] cnt;
  logic        wait_q;
  logic        overrun_q;

  // Shared decodes
  logic        rise, ack_ev, wr_ok, wr_hi, lat_hit, erase_last;
  logic [23:0] wr_word;
  req_t        lat_req, hi_req;
  logic        unused_addr_lsb;

  // Actions decided this cycle, applied by the datapath register
  logic        issue;
  req_t        issue_req;
  logic        pend_load, pend_clr, lat_load, lat_clr;
  logic        cnt_clr, cnt_inc, wait_set, wait_clr;

  // Byte address bit 0 is always zero for halfword transfers.
  assign unused_addr_lsb = ioctl_addr[0];

  assign rise       = dl_active & ~dl_prev;
  assign ack_ev     = stb & wb_ack;
  assign wr_ok      = ioctl_wr & ~wait_q;
  assign wr_hi      = ioctl_addr[1];
  assign wr_word    = ROM_BASE + {1'b0, ioctl_addr[24:2]};
  assign lat_hit    = lat_vld && (lat_word == wr_word);
  assign erase_last = (cnt == ERASE_LAST);
  assign lat_req    = '{adr: lat_word, sel: 4'b0011, dat: {lat_half, lat_half}};
  assign hi_req     = '{adr: wr_word, sel: 4'b1100, dat: {ioctl_dout, ioctl_dout}};

  assign wb_cyc     = stb;
  assign wb_stb     = stb;
  assign wb_we      = stb;
  assign wb_adr     = bus.adr;
  assign wb_sel     = bus.sel;
  assign wb_dat     = bus.dat;
  assign ioctl_wait = wait_q;
  assign overrun    = overrun_q;

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: a cycle in flight is never abandoned, transitions wait for its ack
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (rise) state_nxt = ERASE;
      ERASE: begin
        if (ack_ev) begin
          if (!dl_active)      state_nxt = IDLE;
          else if (erase_last) state_nxt = LOAD;
        end else if (!stb && !dl_active) begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (!dl_active)                   state_nxt = FLUSH;
        else if (wr_ok && (lat_vld || wr_hi)) state_nxt = WRITE;
      end
      WRITE:  if (ack_ev && !pend_vld) state_nxt = dl_active ? LOAD : FLUSH;
      FLUSH:  if (ack_ev || (!stb && !lat_vld)) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: status flags and the datapath actions for this cycle
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FINISH);
    issue     = 1'b0;
    issue_req = '0;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    lat_load  = 1'b0;
    lat_clr   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    wait_set  = 1'b0;
    wait_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          issue     = 1'b1;
          issue_req = '{adr: 24'd0, sel: 4'hF, dat: 32'd0};
          cnt_clr   = 1'b1;
          lat_clr   = 1'b1;
          pend_clr  = 1'b1;
          wait_set  = 1'b1;
        end
      end
      ERASE: begin
        if (ack_ev) begin
          cnt_inc = 1'b1;
          if (!dl_active || erase_last) wait_clr = 1'b1;
        end else if (!stb) begin
          if (dl_active) begin
            issue     = 1'b1;
            issue_req = '{adr: cnt, sel: 4'hF, dat: 32'd0};
          end else begin
            wait_clr = 1'b1;
          end
        end
      end
      LOAD: begin
        if (dl_active && wr_ok) begin
          if (!wr_hi) begin
            // Low half: flush any older half first, then hold the new one.
            if (lat_vld) begin
              issue     = 1'b1;
              issue_req = lat_req;
              wait_set  = 1'b1;
            end
            lat_load = 1'b1;
          end else if (lat_hit) begin
            issue     = 1'b1;
            issue_req = '{adr: wr_word, sel: 4'hF, dat: {ioctl_dout, lat_half}};
            lat_clr   = 1'b1;
            wait_set  = 1'b1;
          end else begin
            // Unpaired high half: stale low half goes out first, high half queued behind it.
            issue    = 1'b1;
            wait_set = 1'b1;
            if (lat_vld) begin
              issue_req = lat_req;
              pend_load = 1'b1;
              lat_clr   = 1'b1;
            end else begin
              issue_req = hi_req;
            end
          end
        end
      end
      WRITE: begin
        if (!stb && pend_vld) begin
          issue     = 1'b1;
          issue_req = pend;
          pend_clr  = 1'b1;
        end else if (ack_ev && !pend_vld && dl_active) begin
          wait_clr = 1'b1;
        end
      end
      FLUSH: begin
        if (!stb && lat_vld) begin
          issue     = 1'b1;
          issue_req = lat_req;
          lat_clr   = 1'b1;
        end
      end
      FINISH: wait_clr = 1'b1;
      default: ;
    endcase
  end

  // Datapath: bus request, second-write queue, halfword latch, erase counter, handshake flags
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_prev   <= 1'b0;
      stb       <= 1'b0;
      bus       <= '0;
      pend_vld  <= 1'b0;
      pend      <= '0;
      lat_vld   <= 1'b0;
      lat_word  <= '0;
      lat_half  <= '0;
      cnt       <= '0;
      wait_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dl_prev <= dl_active;

      if (issue) begin
        stb <= 1'b1;
        bus <= issue_req;
      end else if (ack_ev) begin
        stb <= 1'b0;
      end

      if (pend_load) begin
        pend_vld <= 1'b1;
        pend     <= hi_req;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end

      if (lat_load) begin
        lat_vld  <= 1'b1;
        lat_word <= wr_word;
        lat_half <= ioctl_dout;
      end else if (lat_clr) begin
        lat_vld <= 1'b0;
      end

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 24'd1;

      if (wait_set)      wait_q <= 1'b1;
      else if (wait_clr) wait_q <= 1'b0;

      if (rise)                   overrun_q <= 1'b0;
      else if (ioctl_wr && wait_q) overrun_q <= 1'b1;
    end
  end

endmodule

// File: doc/riscos_loader.md
# riscos_loader

Download-to-SDRAM bridge between the HPS ioctl stream and the SDRAM wishbone port. It zero-fills RAM when a RISC OS image download starts, then packs 16-bit ioctl halfwords into 32-bit wishbone writes at the ROM base. It throttles the HPS with `ioctl_wait` and reports completion. It drives the SDRAM wishbone master side only while `dl_active` is high; the top level muxes it against the CPU.

## Interface
- `ERASE_WORDS`, default 2^20 — number of 32-bit words zeroed from word address 0.
- `ROM_BASE`, default 24'h100000 — word address (byte 0x400000) where ioctl byte 0 lands.
- `clk_sys` in 1 — system clock; all logic on its rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `dl_active` in 1 — RISC OS download in progress (index 1 and download).
- `ioctl_wr` in 1 — one-cycle strobe: halfword valid.
- `ioctl_addr` in 25 — byte address; bit 0 always 0.
- `ioctl_dout` in 16 — halfword data.
- `ioctl_wait` out 1 — registered; stall request to the HPS.
- `wb_cyc`, `wb_stb` out 1 each — always equal; request.
- `wb_we` out 1 — constant 1 while `wb_stb`.
- `wb_sel` out 4 — byte enables.
- `wb_adr` out 24 — word address [25:2].
- `wb_dat` out 32 — write data.
- `wb_ack` in 1 — one-cycle acknowledge.
- `busy` out 1 — state is not IDLE.
- `done` out 1 — one-cycle pulse on normal completion.
- `overrun` out 1 — sticky; an `ioctl_wr` arrived while `ioctl_wait` was high. Cleared on the next rising edge of `dl_active`.

## Operation
States: IDLE, ERASE, LOAD, WRITE, FLUSH, FINISH.
- IDLE → ERASE on a rising edge of `dl_active` (registered history bit). Entry sets `ioctl_wait`=1, erase counter=0, latch invalid, `overrun`=0.
- ERASE: issue a write at `adr`=counter, `sel`=1111, `dat`=0.
  - On `wb_ack`, counter+1.
  - After the ack with counter = `ERASE_WORDS`-1: go to LOAD and clear `ioctl_wait`.
- LOAD, on `ioctl_wr`, with word = `ROM_BASE` + `ioctl_addr[24:2]`:
  - Low half (`addr[1]`=0), latch empty: store data and word in the latch; no bus cycle.
  - Low half, latch valid: write the old latch first (`sel` 0011, `dat`={h,h}), then latch the new half.
  - High half, latch valid and same word: write `sel` 1111, `dat`={new,latched}, invalidate the latch.
  - High half otherwise: if the latch is valid, write it first (`sel` 0011), then write `sel` 1100, `dat`={h,h}.
  - Any bus write sets `ioctl_wait`=1 on the next edge. Go to WRITE; a two-write sequence uses WRITE twice.
- WRITE: hold `stb`/`adr`/`sel`/`dat` stable until `wb_ack`. Then return to LOAD and clear `ioctl_wait`, or issue the queued second write.
- A falling `dl_active` in LOAD → FLUSH. If the latch is valid, write it with `sel` 0011. Then → FINISH.
- FINISH: pulse `done` for one cycle → IDLE.
- `dl_active` falling during ERASE or WRITE: the outstanding cycle stays asserted until `wb_ack` (never drop `stb` before ack). Then:
  - from ERASE → IDLE, no `done`;
  - from WRITE → FLUSH.
- `ioctl_wr` while `ioctl_wait`=1: data is dropped and `overrun`=1.

## Timing
- Reset values: all outputs 0; state IDLE; latch invalid; counter 0.
- Rising `dl_active` at edge N: `ioctl_wait`=1 and `stb`=1 at N+1.
- Bus request: `stb` rises one cycle after the decision. `stb` drops on the edge where `wb_ack` is sampled. The next request may be asserted no earlier than the following edge, so `stb` has a minimum one-cycle low gap.
- `ioctl_wr` at edge N needing a write: `stb`=1 and `ioctl_wait`=1 at N+1. `ioctl_wait` returns to 0 the cycle after the final ack.
- Latch-only halfword: zero bus cycles; `ioctl_wait` stays 0.
- Erase cost: `ERASE_WORDS` × (SDRAM ack latency + 1) cycles.
- `reset_n` low at any point: immediate return to reset values, even mid-cycle, because SDRAM is reset alongside.

## Test plan
- Erase: `ERASE_WORDS`=8, ack 3 cycles after `stb`. Raise `dl_active` → 8 writes to adr 0..7, `sel` F, `dat` 0; `ioctl_wait` high throughout, then low.
- Pack: write addr 0 = 16'h1234, then addr 2 = 16'h5678 → a single write at adr 24'h100000, `sel` F, `dat` 32'h56781234; no bus cycle after the first halfword.
- Odd tail: write addr 4 = 16'hBEEF, then drop `dl_active` → a write at adr 24'h100001, `sel` 0011, `dat` 32'hBEEFBEEF, followed by a `done` pulse.
- Unpaired halves: addr 0 = 16'hAAAA, then addr 6 = 16'hBBBB → write adr 24'h100000 `sel` 0011, then adr 24'h100001 `sel` 1100 `dat` 32'hBBBBBBBB.
- Protocol: hold `wb_ack` low for 20 cycles → `stb`/`adr`/`dat` stable. An `ioctl_wr` injected during this stall sets `overrun` and the data is not written.
- Abort: drop `dl_active` mid-erase → the current cycle completes, then IDLE with no `done`. Assert `reset_n`=0 mid-write → all outputs 0 immediately.
